// File: rtl/t07_mmio_responder_pkg.sv
// Shared types and constants for the MMIO responder.
package t07_mmio_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RSV   = 2'b11
  } rwi_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [31:0] ERR_DATA = 32'hBAD0_BAD0;
  localparam int unsigned CNT_W    = 4;

endpackage

// File: rtl/t07_mmio_responder_if.sv
// CPU external memory port bundle between the core (master) and the responder (slave).
interface t07_mmio_responder_if;
  logic [1:0]  rwi_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        busy_o;
  logic        err_o;

  modport master (output rwi_i, output addr_i, output data_i,
                  input  data_o, input busy_o, input err_o);
  modport slave  (input  rwi_i, input  addr_i, input  data_i,
                  output data_o, output busy_o, output err_o);
endinterface

// File: rtl/t07_resp_mem.sv
// Word store with synchronous write, registered read and async clear.
module t07_resp_mem #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      if (we) mem_q[idx] <= wdata;
      if (re) rdata_q <= mem_q[idx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/t07_mmio_responder.sv
// Target side of the CPU external memory port: programmable busy wait, then access to a local store.
module t07_mmio_responder
  import t07_mmio_pkg::*;
#(
  parameter int unsigned DEPTH       = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                  clk,
  input logic                  nrst,
  t07_mmio_responder_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] SPAN  = 32'(DEPTH * 4);

  state_t             state_q, state_d;
  rwi_t               cmd_q, cmd_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        data_q, data_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic [31:0]        addr_sel;
  logic [31:0]        offset;
  logic               in_range;
  logic [IDX_W-1:0]   mem_idx;
  logic               mem_we;
  logic               mem_re;
  logic [31:0]        mem_rdata;

  // In IDLE the store is addressed from the live bus so a read is prefetched
  // at the capture edge; in WAIT it is addressed from the captured request.
  always_comb begin
    addr_sel = (state_q == IDLE) ? bus.addr_i : addr_q;
    offset   = addr_sel - BASE_ADDR;
    in_range = (offset < SPAN);
    mem_idx  = offset[IDX_W+1:2];
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        case (rwi_t'(bus.rwi_i))
          CMD_WRITE, CMD_READ: begin
            cmd_d   = rwi_t'(bus.rwi_i);
            addr_d  = bus.addr_i;
            wdata_d = bus.data_i;
            cnt_d   = CNT_W'(WAIT_CYCLES);
            busy_d  = 1'b1;
            state_d = WAIT;
            mem_re  = (rwi_t'(bus.rwi_i) == CMD_READ);
          end
          CMD_RSV: err_d = 1'b1;
          default: ;
        endcase
      end
      WAIT: begin
        mem_re = (cmd_q == CMD_READ);
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          busy_d  = 1'b0;
          state_d = IDLE;
          if (cmd_q == CMD_READ) begin
            data_d = in_range ? mem_rdata : ERR_DATA;
            err_d  = !in_range;
          end else begin
            mem_we = in_range;
            err_d  = !in_range;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cmd_q   <= CMD_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  t07_resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .nrst  (nrst),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (mem_idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  assign bus.data_o = data_q;
  assign bus.busy_o = busy_q;
  assign bus.err_o  = err_q;

endmodule

// File: tb/tb_t07_mmio_responder.sv
// Scoreboard bench for t07_mmio_responder at WAIT_CYCLES=2 and WAIT_CYCLES=0.
module tb_t07_mmio_responder;

  logic clk;
  logic nrst;
  int   total;
  int   bad;

  logic [31:0] exp_q [$];
  logic [31:0] model_mem [256];

  t07_mmio_responder_if if2 ();
  t07_mmio_responder_if if0 ();

  t07_mmio_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut2 (
    .clk (clk), .nrst (nrst), .bus (if2.slave));
  t07_mmio_responder #(.DEPTH(256), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) dut0 (
    .clk (clk), .nrst (nrst), .bus (if0.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input bit use0, input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] d);
    if (use0) begin
      if0.rwi_i = cmd; if0.addr_i = a; if0.data_i = d;
    end else begin
      if2.rwi_i = cmd; if2.addr_i = a; if2.data_i = d;
    end
  endtask

  // Issues one command, optionally presents other values while busy, and
  // reports busy length, err pulses and the final data_o.
  task automatic access(input bit use0, input logic [1:0] cmd, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] cmd2, input logic [31:0] a2,
                        input logic [31:0] d2, output int bc, output int ec,
                        output logic [31:0] dout, output logic busy_end);
    logic b, e;
    bc = 0; ec = 0;
    @(negedge clk);
    drive(use0, cmd, a, d);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      b = use0 ? if0.busy_o : if2.busy_o;
      e = use0 ? if0.err_o  : if2.err_o;
      if (b) bc++;
      if (e) ec++;
      if (b) drive(use0, cmd2, a2, d2);
      else   drive(use0, 2'b00, 32'h0, 32'h0);
    end
    dout     = use0 ? if0.data_o : if2.data_o;
    busy_end = use0 ? if0.busy_o : if2.busy_o;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 2'b00, 32'h0, 32'h0);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 3) nrst = 1'b1;
      total++;
      if ({if2.busy_o, if2.err_o, if2.data_o} !== 34'h0 ||
          {if0.busy_o, if0.err_o, if0.data_o} !== 34'h0) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got busy=%b err=%b data=%h want 0/0/0",
                 i, if2.busy_o, if2.err_o, if2.data_o);
      end
    end
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
  endtask

  task automatic test_write_read();
    int bc, ec; logic [31:0] dout, want; logic be;
    access(1'b0, 2'b01, 32'h10, 32'hDEAD_BEEF, 2'b00, 0, 0, bc, ec, dout, be);
    model_mem[4] = 32'hDEAD_BEEF;
    total++;
    if (bc !== 3 || ec !== 0 || be !== 1'b0) begin
      bad++; $display("FAIL wr_busy got bc=%0d ec=%0d want bc=3 ec=0", bc, ec);
    end
    exp_q.push_back(model_mem[4]);
    access(1'b0, 2'b10, 32'h10, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (bc !== 3 || ec !== 0 || dout !== want) begin
      bad++; $display("FAIL rd_after_wr got bc=%0d ec=%0d data=%h want 3/0/%h", bc, ec, dout, want);
    end
  endtask

  task automatic test_back_to_back();
    int bc; logic b;
    bc = 0;
    @(negedge clk);
    drive(1'b0, 2'b10, 32'h10, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b = if2.busy_o;
      if (b) bc++;
    end
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    total++;
    if (bc !== 6 || if2.data_o !== model_mem[4]) begin
      bad++; $display("FAIL back_to_back got busy_cycles=%0d data=%h want 6/%h", bc, if2.data_o, model_mem[4]);
    end
  endtask

  task automatic test_ignored();
    int bc, ec; logic [31:0] dout, want; logic be;
    exp_q.push_back(model_mem[1]);
    access(1'b0, 2'b10, 32'h4, 32'h0, 2'b01, 32'h8, 32'hFFFF_0000, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (bc !== 3 || dout !== want) begin
      bad++; $display("FAIL ignore_rd got bc=%0d data=%h want 3/%h", bc, dout, want);
    end
    exp_q.push_back(model_mem[2]);
    access(1'b0, 2'b10, 32'h8, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (dout !== want || ec !== 0) begin
      bad++; $display("FAIL ignore_mem2 got data=%h ec=%0d want %h/0", dout, ec, want);
    end
  endtask

  task automatic test_out_of_range();
    int bc, ec; logic [31:0] dout, want; logic be;
    exp_q.push_back(32'hBAD0_BAD0);
    access(1'b0, 2'b10, 32'h400, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (dout !== want || ec !== 1 || bc !== 3) begin
      bad++; $display("FAIL oor_read got data=%h ec=%0d bc=%0d want %h/1/3", dout, ec, bc, want);
    end
    access(1'b0, 2'b01, 32'hFFFF_FFFC, 32'h5555_5555, 2'b00, 0, 0, bc, ec, dout, be);
    total++;
    if (ec !== 1 || dout !== 32'hBAD0_BAD0) begin
      bad++; $display("FAIL oor_write got ec=%0d data=%h want 1/bad0bad0", ec, dout);
    end
    exp_q.push_back(model_mem[255]);
    access(1'b0, 2'b10, 32'h3FC, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (dout !== want || ec !== 0) begin
      bad++; $display("FAIL oor_nostore got data=%h ec=%0d want %h/0", dout, ec, want);
    end
  endtask

  task automatic test_rsv_w0();
    int bc, ec; logic [31:0] dout, want; logic be;
    access(1'b1, 2'b11, 32'h0, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    total++;
    if (ec !== 1 || bc !== 0) begin
      bad++; $display("FAIL rsv_cmd got ec=%0d bc=%0d want 1/0", ec, bc);
    end
    exp_q.push_back(32'h0);
    access(1'b1, 2'b10, 32'h0, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (bc !== 1 || dout !== want || ec !== 0) begin
      bad++; $display("FAIL w0_read got bc=%0d data=%h ec=%0d want 1/%h/0", bc, dout, ec, want);
    end
    access(1'b1, 2'b01, 32'h3FC, 32'hA5A5_0F0F, 2'b00, 0, 0, bc, ec, dout, be);
    exp_q.push_back(32'hA5A5_0F0F);
    access(1'b1, 2'b10, 32'h3FC, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (bc !== 1 || dout !== want) begin
      bad++; $display("FAIL w0_last_word got bc=%0d data=%h want 1/%h", bc, dout, want);
    end
  endtask

  task automatic test_reset_mid_write();
    int bc, ec; logic [31:0] dout, want; logic be;
    @(negedge clk);
    drive(1'b0, 2'b01, 32'h20, 32'h1234_5678);
    @(negedge clk);
    drive(1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    total++;
    if (if2.busy_o !== 1'b1) begin
      bad++; $display("FAIL mid_busy_pre got %b want 1", if2.busy_o);
    end
    nrst = 1'b0;
    #1;
    total++;
    if (if2.busy_o !== 1'b0) begin
      bad++; $display("FAIL mid_busy_rst got %b want 0", if2.busy_o);
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    repeat (4) @(negedge clk);
    exp_q.push_back(model_mem[8]);
    access(1'b0, 2'b10, 32'h20, 32'h0, 2'b00, 0, 0, bc, ec, dout, be);
    want = exp_q.pop_front();
    total++;
    if (dout !== want || bc !== 3) begin
      bad++; $display("FAIL mid_write_aborted got data=%h bc=%0d want %h/3", dout, bc, want);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_ignored();
    test_out_of_range();
    test_rsv_w0();
    test_reset_mid_write();
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_left got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
